// File: rtl/mem_req_flow_ctrl.sv
// rtl/mem_req_flow_ctrl.sv - request skid buffer, in-flight cap, response pass-through and error watchdog
package mem_req_flow_ctrl_pkg;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } mem_resp_t;
endpackage

module mem_req_flow_ctrl
    import mem_req_flow_ctrl_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_req_valid,
    output logic             up_req_ready,
    input  mem_req_t         up_req,
    output logic             up_resp_valid,
    input  logic             up_resp_ready,
    output mem_resp_t        up_resp,
    output logic             dn_req_valid,
    input  logic             dn_req_ready,
    output mem_req_t         dn_req,
    input  logic             dn_resp_valid,
    output logic             dn_resp_ready,
    input  mem_resp_t        dn_resp,
    input  logic             err_clr,
    output logic [CNT_W-1:0] outstanding,
    output logic             idle,
    output logic             resp_err,
    output logic             timeout_err
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUT);

    mem_req_t         buf_q [0:1];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] out_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             resp_err_q;
    logic             timeout_err_q;

    logic up_fire, dn_fire, resp_fire, solicited, resp_cnt, wd_active, wd_expire;

    // Ready depends only on registered occupancy so no combinational path reaches the core from the bridge.
    assign up_req_ready  = ~rst & (count != 2'd2);
    assign dn_req_valid  = (count != 2'd0) & (out_cnt < OUT_MAX);
    assign dn_req        = buf_q[rd_ptr];

    assign up_fire   = up_req_valid & up_req_ready;
    assign dn_fire   = dn_req_valid & dn_req_ready;
    assign solicited = (out_cnt != '0) | dn_fire;

    // With nothing in flight a response is swallowed rather than forwarded.
    assign up_resp_valid = solicited & dn_resp_valid;
    assign up_resp       = dn_resp;
    assign dn_resp_ready = solicited ? up_resp_ready : 1'b1;
    assign resp_fire     = dn_resp_valid & dn_resp_ready;
    assign resp_cnt      = resp_fire & solicited;

    assign wd_active = (out_cnt != '0) & ~resp_fire;
    assign wd_expire = (TIMEOUT != 0) & wd_active & (wd_cnt == WD_MAX);

    assign outstanding = out_cnt;
    assign idle        = (count == 2'd0) & (out_cnt == '0);
    assign resp_err    = resp_err_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (up_fire) begin
            buf_q[wr_ptr] <= up_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (up_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (dn_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            if (up_fire & ~dn_fire) begin
                count <= count + 2'd1;
            end else if (dn_fire & ~up_fire) begin
                count <= count - 2'd1;
            end
        end
    end

    // A counted response with out_cnt==0 only happens alongside dn_fire, so this cannot underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (dn_fire & ~resp_cnt) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (resp_cnt & ~dn_fire) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || TIMEOUT == 0 || !wd_active) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            resp_err_q    <= (resp_fire & ~solicited) | (resp_err_q & ~err_clr);
            timeout_err_q <= wd_expire | (timeout_err_q & ~err_clr);
        end
    end
endmodule

// File: tb/tb_mem_req_flow_ctrl.sv
// tb/tb_mem_req_flow_ctrl.sv - vector table, directed corner sequences and random traffic against a queue model
module tb_mem_req_flow_ctrl;
    import mem_req_flow_ctrl_pkg::*;

    localparam int MAX_OUT = 2;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             up_req_valid, up_req_ready;
    mem_req_t         up_req;
    logic             up_resp_valid, up_resp_ready;
    mem_resp_t        up_resp;
    logic             dn_req_valid, dn_req_ready;
    mem_req_t         dn_req;
    logic             dn_resp_valid, dn_resp_ready;
    mem_resp_t        dn_resp;
    logic             err_clr;
    logic [CNT_W-1:0] outstanding;
    logic             idle, resp_err, timeout_err;

    mem_req_flow_ctrl #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req(up_req),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp(up_resp),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req(dn_req),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .dn_resp(dn_resp),
        .err_clr(err_clr), .outstanding(outstanding), .idle(idle),
        .resp_err(resp_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    mem_req_t mq[$];
    int       m_out   = 0;
    int       m_quiet = 0;
    bit       m_rerr  = 0;
    bit       m_terr  = 0;

    typedef struct {
        bit        r, uv;
        mem_req_t  ur;
        bit        dr, rv;
        mem_resp_t rr;
        bit        urr, ec;
        bit        e_urdy, e_dv;
        mem_req_t  e_dreq;
        bit        e_urv;
        mem_resp_t e_uresp;
        bit        e_drr;
        int        e_out;
        bit        e_idle, e_rerr;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic mem_req_t req_of(input int i);
        mem_req_t q;
        q.we    = i[0];
        q.addr  = 16'h1000 + 16'(i);
        q.wdata = 16'hA500 + 16'(i);
        return q;
    endfunction

    function automatic mem_resp_t resp_of(input int i);
        mem_resp_t p;
        p.err   = i[1];
        p.rdata = 16'h5A00 + 16'(i);
        return p;
    endfunction

    // Drive one cycle, compare every output against the model, then advance the model past the edge.
    task automatic step(input bit r, input bit uv, input mem_req_t ur, input bit dr,
                        input bit rv, input mem_resp_t rr, input bit urr, input bit ec);
        bit e_urdy, e_dv, dn_f, sol, e_urv, e_drr, rf, up_f;
        @(negedge clk);
        rst = r; up_req_valid = uv; up_req = ur; dn_req_ready = dr;
        dn_resp_valid = rv; dn_resp = rr; up_resp_ready = urr; err_clr = ec;
        #1;
        e_urdy = !r && (mq.size() < 2);
        e_dv   = (mq.size() != 0) && (m_out < MAX_OUT);
        dn_f   = e_dv && dr;
        sol    = (m_out != 0) || dn_f;
        e_urv  = sol && rv;
        e_drr  = sol ? urr : 1'b1;
        rf     = rv && e_drr;
        check("up_req_ready",  64'(up_req_ready),  64'(e_urdy));
        check("dn_req_valid",  64'(dn_req_valid),  64'(e_dv));
        check("up_resp_valid", 64'(up_resp_valid), 64'(e_urv));
        check("dn_resp_ready", 64'(dn_resp_ready), 64'(e_drr));
        check("outstanding",   64'(outstanding),   64'(m_out));
        check("idle",          64'(idle),          64'(mq.size() == 0 && m_out == 0));
        check("resp_err",      64'(resp_err),      64'(m_rerr));
        check("timeout_err",   64'(timeout_err),   64'(m_terr));
        if (e_dv)  check("dn_req",  64'(dn_req),  64'(mq[0]));
        if (e_urv) check("up_resp", 64'(up_resp), 64'(rr));
        if (r) begin
            mq.delete();
            m_out = 0; m_quiet = 0; m_rerr = 0; m_terr = 0;
        end else begin
            up_f = uv && e_urdy;
            if (dn_f) void'(mq.pop_front());
            if (up_f) mq.push_back(ur);
            m_quiet = (m_out != 0 && !rf) ? m_quiet + 1 : 0;
            m_terr  = (m_quiet >= TIMEOUT) || (m_terr && !ec);
            m_rerr  = (rf && !sol) || (m_rerr && !ec);
            m_out   = m_out + (dn_f ? 1 : 0) - ((rf && sol) ? 1 : 0);
        end
    endtask

    task automatic nop(input bit dr);
        step(0, 0, '0, dr, 0, '0, 0, 0);
    endtask

    task automatic push(input int i, input bit dr);
        step(0, 1, req_of(i), dr, 0, '0, 0, 0);
    endtask

    task automatic respond(input int i, input bit dr, input bit urr);
        step(0, 0, '0, dr, 1, resp_of(i), urr, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        mem_req_t  ra;
        mem_resp_t rr0;
        ra  = req_of(1);
        rr0 = resp_of(1);
        //            r uv ur  dr rv rr   urr ec | urdy dv dreq urv uresp drr out idle rerr
        tbl[0] = '{1, 0, '0, 0, 0, '0,  0, 0,  0, 0, '0, 0, '0,  1, 0, 1, 0};
        tbl[1] = '{0, 1, ra, 0, 0, '0,  0, 0,  1, 0, '0, 0, '0,  1, 0, 1, 0};
        tbl[2] = '{0, 0, '0, 1, 0, '0,  0, 0,  1, 1, ra, 0, '0,  0, 0, 0, 0};
        tbl[3] = '{0, 0, '0, 0, 1, rr0, 1, 0,  1, 0, '0, 1, rr0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, '0, 0, 0, '0,  0, 0,  1, 0, '0, 0, '0,  1, 0, 1, 0};
        tbl[5] = '{0, 0, '0, 0, 1, rr0, 0, 0,  1, 0, '0, 0, '0,  1, 0, 1, 0};
        tbl[6] = '{0, 0, '0, 0, 0, '0,  0, 0,  1, 0, '0, 0, '0,  1, 0, 1, 1};
        tbl[7] = '{0, 0, '0, 0, 0, '0,  0, 1,  1, 0, '0, 0, '0,  1, 0, 1, 1};
        tbl[8] = '{0, 0, '0, 0, 0, '0,  0, 0,  1, 0, '0, 0, '0,  1, 0, 1, 0};

        rst = 1; up_req_valid = 0; up_req = '0; dn_req_ready = 0;
        dn_resp_valid = 0; dn_resp = '0; up_resp_ready = 0; err_clr = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].uv, tbl[i].ur, tbl[i].dr, tbl[i].rv, tbl[i].rr, tbl[i].urr, tbl[i].ec);
            check($sformatf("tbl%0d_up_req_ready", i),  64'(up_req_ready),  64'(tbl[i].e_urdy));
            check($sformatf("tbl%0d_dn_req_valid", i),  64'(dn_req_valid),  64'(tbl[i].e_dv));
            if (tbl[i].e_dv) check($sformatf("tbl%0d_dn_req", i), 64'(dn_req), 64'(tbl[i].e_dreq));
            check($sformatf("tbl%0d_up_resp_valid", i), 64'(up_resp_valid), 64'(tbl[i].e_urv));
            if (tbl[i].e_urv) check($sformatf("tbl%0d_up_resp", i), 64'(up_resp), 64'(tbl[i].e_uresp));
            check($sformatf("tbl%0d_dn_resp_ready", i), 64'(dn_resp_ready), 64'(tbl[i].e_drr));
            check($sformatf("tbl%0d_outstanding", i),   64'(outstanding),   64'(tbl[i].e_out));
            check($sformatf("tbl%0d_idle", i),          64'(idle),          64'(tbl[i].e_idle));
            check($sformatf("tbl%0d_resp_err", i),      64'(resp_err),      64'(tbl[i].e_rerr));
        end

        // Cap at MAX_OUT: A,B issue, C,D buffered
        push(10, 1); push(11, 1); push(12, 1); push(13, 1);
        nop(1);
        check("cap_up_req_ready", 64'(up_req_ready), 64'(0));
        check("cap_outstanding",  64'(outstanding),  64'(2));
        check("cap_dn_req_valid", 64'(dn_req_valid), 64'(0));
        respond(20, 1, 1);
        check("cap_resp_fwd", 64'(up_resp_valid), 64'(1));
        nop(1);
        check("cap_issue_c_valid", 64'(dn_req_valid), 64'(1));
        check("cap_issue_c_data",  64'(dn_req),       64'(req_of(12)));

        // Full buffer held under backpressure, then drained in order
        push(14, 0);
        respond(21, 0, 1); respond(22, 0, 1);
        for (int k = 0; k < 5; k++) begin
            nop(0);
            check("bp_dn_req_stable", 64'(dn_req),       64'(req_of(13)));
            check("bp_up_req_ready",  64'(up_req_ready), 64'(0));
        end
        nop(1);
        check("drain_first",  64'(dn_req), 64'(req_of(13)));
        nop(1);
        check("drain_second", 64'(dn_req), 64'(req_of(14)));
        nop(1);
        check("drain_empty",  64'(dn_req_valid), 64'(0));
        respond(23, 0, 1); respond(24, 0, 1);

        // Simultaneous issue and response with one in flight
        push(30, 0); nop(1); push(31, 0);
        step(0, 0, '0, 1, 1, resp_of(30), 1, 0);
        nop(0);
        check("same_cycle_outstanding", 64'(outstanding), 64'(1));
        respond(31, 0, 1);
        step(0, 0, '0, 0, 1, resp_of(32), 0, 0);
        check("unsol_up_resp_valid", 64'(up_resp_valid), 64'(0));
        check("unsol_dn_resp_ready", 64'(dn_resp_ready), 64'(1));
        step(0, 0, '0, 0, 0, '0, 0, 1);
        check("unsol_resp_err_set", 64'(resp_err), 64'(1));
        nop(0);
        check("unsol_resp_err_clr", 64'(resp_err), 64'(0));

        // Watchdog: error visible 8 cycles after dn_fire
        push(40, 0); nop(1);
        for (int j = 1; j <= 9; j++) begin
            nop(0);
            if (j == 8) check("wd_before_expiry", 64'(timeout_err), 64'(0));
            if (j == 9) check("wd_expired",       64'(timeout_err), 64'(1));
        end
        respond(41, 0, 1);
        check("wd_late_resp_fwd", 64'(up_resp_valid), 64'(1));
        nop(0);
        check("wd_sticky",       64'(timeout_err), 64'(1));
        check("wd_outstanding0", 64'(outstanding), 64'(0));
        step(0, 0, '0, 0, 0, '0, 0, 1);
        nop(0);
        check("wd_cleared", 64'(timeout_err), 64'(0));

        // Reset mid-operation with two buffered and one in flight
        step(0, 0, '0, 0, 1, resp_of(50), 0, 0);
        push(51, 0); nop(1); push(52, 0); push(53, 0);
        step(1, 0, '0, 0, 0, '0, 0, 0);
        check("rst_up_req_ready_low", 64'(up_req_ready), 64'(0));
        nop(0);
        check("rst_outstanding",  64'(outstanding),  64'(0));
        check("rst_dn_req_valid", 64'(dn_req_valid), 64'(0));
        check("rst_idle",         64'(idle),         64'(1));
        check("rst_resp_err",     64'(resp_err),     64'(0));
        check("rst_timeout_err",  64'(timeout_err),  64'(0));
        check("rst_up_req_ready", 64'(up_req_ready), 64'(1));

        for (int c = 0; c < 2000; c++) begin
            mem_req_t  rq;
            mem_resp_t rp;
            rq = mem_req_t'($urandom);
            rp = mem_resp_t'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rq,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, rp,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
